// File: rtl/wb_trace_buffer_if.sv
// wb_trace_buffer_if: writeback capture and read-port bundle for wb_trace_buffer
//   capture in : wbData, wbValid, arm, trigEn, trigValue
//   read in    : rdEn
//   read out   : rdData, rdValid
//   status out : count, full, empty, overflow, state
//   master = producer/debug side, slave = trace buffer
interface wb_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 4
);
  logic [DATA_W-1:0] wbData;
  logic              wbValid;
  logic              arm;
  logic              trigEn;
  logic [DATA_W-1:0] trigValue;
  logic              rdEn;
  logic [DATA_W-1:0] rdData;
  logic              rdValid;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic [1:0]        state;
  modport master (
    output wbData, wbValid, arm, trigEn, trigValue, rdEn,
    input  rdData, rdValid, count, full, empty, overflow, state
  );
  modport slave (
    input  wbData, wbValid, arm, trigEn, trigValue, rdEn,
    output rdData, rdValid, count, full, empty, overflow, state
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: circular trace buffer capturing the writeback result stream
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : wb_trace_buffer_if.slave (capture inputs, registered read port, status)
module wb_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input logic              clk,
  input logic              rst_n,
  wb_trace_buffer_if.slave bus
);
  localparam int CW = AW + 1;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              do_wr, do_rd;
  always_comb begin
    // arm clears the session, so it suppresses any same-cycle write or pop
    do_rd = bus.rdEn && count_q != '0 && !bus.arm;
    do_wr = !bus.arm && bus.wbValid &&
            (state_q == CAPTURE || (state_q == ARMED && bus.wbData == bus.trigValue));
    wr_ptr_d   = bus.arm ? '0 : wr_ptr_q + AW'(do_wr);
    rd_ptr_d   = bus.arm ? '0 : rd_ptr_q + AW'(do_rd);
    count_d    = bus.arm ? '0 : count_q + CW'(do_wr) - CW'(do_rd);
    rd_data_d  = do_rd ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = do_rd;
    overflow_d = bus.arm ? 1'b0 :
                 overflow_q | (state_q == DONE && bus.wbValid && full_q);
    full_d     = count_d == CW'(DEPTH);
    empty_d    = count_d == '0;
    state_d    = bus.arm ? (bus.trigEn ? ARMED : CAPTURE) :
                 (state_q == ARMED && do_wr) ? CAPTURE :
                 // a same-cycle pop keeps room free, so only an unpaired write fills up
                 (state_q == CAPTURE && do_wr && !do_rd && count_q == CW'(DEPTH - 1)) ? DONE :
                 state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= bus.wbData;
  end
  assign bus.rdData   = rd_data_q;
  assign bus.rdValid  = rd_valid_q;
  assign bus.count    = count_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.overflow = overflow_q;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed bench with a queue-based reference model of wb_trace_buffer
module tb_wb_trace_buffer;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  wb_trace_buffer_if #(.DATA_W(32), .AW(4)) bus ();
  wb_trace_buffer #(.DATA_W(32), .DEPTH(DEPTH), .AW(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  logic [31:0] q[$];
  int          ms = 0;
  bit          movf = 1'b0;
  logic [31:0] mrd = '0;
  bit          mrv = 1'b0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step();
    bit pop, wr;
    if (!rst_n) begin
      q.delete();
      ms = 0;
      movf = 1'b0;
      mrd = '0;
      mrv = 1'b0;
    end else if (bus.arm) begin
      q.delete();
      movf = 1'b0;
      ms = bus.trigEn ? 1 : 2;
      mrv = 1'b0;
    end else begin
      pop = bus.rdEn && q.size() > 0;
      wr  = bus.wbValid && (ms == 2 || (ms == 1 && bus.wbData == bus.trigValue));
      if (ms == 3 && bus.wbValid && q.size() == DEPTH) movf = 1'b1;
      mrv = pop;
      if (pop) mrd = q.pop_front();
      if (wr) q.push_back(bus.wbData);
      if (ms == 1 && wr) ms = 2;
      else if (ms == 2 && wr && !pop && q.size() == DEPTH) ms = 3;
    end
  endtask
  always @(posedge clk or negedge rst_n) model_step();
  task automatic compare();
    check("m_count", 32'(bus.count), 32'(q.size()));
    check("m_full", 32'(bus.full), 32'(q.size() == DEPTH));
    check("m_empty", 32'(bus.empty), 32'(q.size() == 0));
    check("m_overflow", 32'(bus.overflow), 32'(movf));
    check("m_state", 32'(bus.state), 32'(ms));
    check("m_rdValid", 32'(bus.rdValid), 32'(mrv));
    check("m_rdData", bus.rdData, mrd);
  endtask
  always @(posedge clk) begin
    #1;
    compare();
  end
  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic a);
    @(negedge clk);
    bus.wbValid = v;
    bus.wbData  = d;
    bus.rdEn    = r;
    bus.arm     = a;
  endtask
  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask
  task automatic read_expect(input string name, input logic [31:0] exp);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    idle();
    check(name, bus.rdData, exp);
    check({name, "_v"}, 32'(bus.rdValid), 32'd1);
  endtask
  initial begin
    bus.wbValid = 1'b0;
    bus.wbData = '0;
    bus.rdEn = 1'b0;
    bus.arm = 1'b0;
    bus.trigEn = 1'b0;
    bus.trigValue = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_rdv", 32'(bus.rdValid), 32'd0);
    // 1: plain capture and in-order drain
    drive(1'b0, 0, 1'b0, 1'b1);
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    drive(1'b1, 32'h33, 1'b0, 1'b0);
    idle();
    check("t1_count", 32'(bus.count), 32'd3);
    check("t1_state", 32'(bus.state), 32'd2);
    read_expect("t1_rd0", 32'h11);
    read_expect("t1_rd1", 32'h22);
    read_expect("t1_rd2", 32'h33);
    check("t1_empty", 32'(bus.empty), 32'd1);
    idle();
    check("t1_rdv_pulse", 32'(bus.rdValid), 32'd0);
    // 2: trigger on value
    bus.trigEn = 1'b1;
    bus.trigValue = 32'hDEAD;
    drive(1'b0, 0, 1'b0, 1'b1);
    drive(1'b1, 32'h1, 1'b0, 1'b0);
    drive(1'b1, 32'h2, 1'b0, 1'b0);
    drive(1'b1, 32'hDEAD, 1'b0, 1'b0);
    check("t2_armed", 32'(bus.state), 32'd1);
    check("t2_armed_cnt", 32'(bus.count), 32'd0);
    drive(1'b1, 32'h3, 1'b0, 1'b0);
    check("t2_capture", 32'(bus.state), 32'd2);
    idle();
    check("t2_count", 32'(bus.count), 32'd2);
    read_expect("t2_rd0", 32'hDEAD);
    read_expect("t2_rd1", 32'h3);
    bus.trigEn = 1'b0;
    // 3: fill, stop on full, overflow, re-arm
    drive(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b1, 32'(i), 1'b0, 1'b0);
    idle();
    check("t3_full", 32'(bus.full), 32'd1);
    check("t3_done", 32'(bus.state), 32'd3);
    drive(1'b1, 32'h99, 1'b0, 1'b0);
    idle();
    check("t3_ovf", 32'(bus.overflow), 32'd1);
    check("t3_count16", 32'(bus.count), 32'd16);
    drive(1'b1, 32'h77, 1'b0, 1'b1);
    idle();
    check("t3_ovf_clr", 32'(bus.overflow), 32'd0);
    check("t3_cnt_clr", 32'(bus.count), 32'd0);
    // 4: pointer wrap
    for (int i = 0; i < 10; i++) drive(1'b1, 32'(i), 1'b0, 1'b0);
    idle();
    check("t4_c10", 32'(bus.count), 32'd10);
    for (int i = 0; i < 8; i++) drive(1'b0, 0, 1'b1, 1'b0);
    idle();
    check("t4_c2", 32'(bus.count), 32'd2);
    check("t4_last", bus.rdData, 32'd7);
    for (int i = 0; i < 10; i++) drive(1'b1, 32'(100 + i), 1'b0, 1'b0);
    idle();
    check("t4_c12", 32'(bus.count), 32'd12);
    read_expect("t4_w8", 32'd8);
    read_expect("t4_w9", 32'd9);
    for (int i = 0; i < 10; i++) read_expect("t4_wrap", 32'(100 + i));
    check("t4_empty", 32'(bus.empty), 32'd1);
    // 5: simultaneous write and pop at DEPTH-1
    drive(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) drive(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
    idle();
    check("t5_c15", 32'(bus.count), 32'd15);
    drive(1'b1, 32'h50F, 1'b1, 1'b0);
    idle();
    check("t5_cnt", 32'(bus.count), 32'd15);
    check("t5_state", 32'(bus.state), 32'd2);
    check("t5_rdv", 32'(bus.rdValid), 32'd1);
    check("t5_rd", bus.rdData, 32'h500);
    drive(1'b1, 32'h510, 1'b0, 1'b0);
    idle();
    check("t5_done", 32'(bus.state), 32'd3);
    // 6: pop on empty, then async reset mid-capture
    drive(1'b0, 0, 1'b1, 1'b1);
    drive(1'b0, 0, 1'b1, 1'b0);
    idle();
    check("t6_rdv0", 32'(bus.rdValid), 32'd0);
    check("t6_hold", bus.rdData, 32'h500);
    for (int i = 0; i < 5; i++) drive(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    idle();
    check("t6_c5", 32'(bus.count), 32'd5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_state", 32'(bus.state), 32'd0);
    check("t6_async_count", 32'(bus.count), 32'd0);
    check("t6_async_empty", 32'(bus.empty), 32'd1);
    repeat (2) idle();
    rst_n = 1'b1;
    idle();
    idle();
    check("t6_post_state", 32'(bus.state), 32'd0);
    check("t6_post_rd", bus.rdData, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Consumer end of the pipeline writeback path: captures the 32-bit writeback-mux result stream (outMuxWb plus a valid qualifier) into a circular trace buffer.
- Supports optional trigger-on-value start, a stop-on-full policy and a sticky overflow flag.
- A registered read port drains captured words in order, so benches and the debug path can inspect retired results without probing pipeline internals.

Parameters:
- DATA_W, 32, width of captured writeback word.
- DEPTH, 16, buffer entries; power of two.
- AW, 4, log2(DEPTH); pointer width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wbData  in  DATA_W  writeback-mux result (driven from outMuxWb)
- wbValid  in  1  wbData carries a retired result this cycle
- arm  in  1  single-cycle pulse: clear buffer and start a capture session
- trigEn  in  1  1 = wait for trigValue before capturing; sampled on arm
- trigValue  in  DATA_W  trigger match value
- rdEn  in  1  pop request
- rdData  out  DATA_W  popped word, registered
- rdValid  out  1  rdData valid, one-cycle pulse
- count  out  AW+1  entries held (0..DEPTH)
- full  out  1  count==DEPTH
- empty  out  1  count==0
- overflow  out  1  sticky: a valid word was dropped while full
- state  out  2  FSM state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE

Behaviour:
- Reset (async, rst_n low): state=IDLE; pointers, count, rdData, rdValid, overflow = 0; empty=1; full=0. Storage contents undefined. Deassertion takes effect at the next clk edge.
- All outputs registered; count/full/empty reflect writes and reads one cycle after the causing edge.
- FSM, IDLE: wbValid ignored. On arm, go to ARMED if trigEn=1, else CAPTURE.
- FSM, ARMED: a cycle with wbValid=1 and wbData==trigValue writes that word and moves to CAPTURE. Non-matching words are discarded.
- FSM, CAPTURE: every wbValid cycle writes wbData at wrPtr; wrPtr increments modulo DEPTH. When a write without a same-cycle pop makes count reach DEPTH, move to DONE.
- FSM, DONE: no writes. wbValid while full sets overflow. Remains in DONE until arm, even if reads free space.
- arm in any state: next cycle wrPtr=rdPtr=count=0 and overflow=0; state goes to ARMED or CAPTURE per trigEn.
- arm wins over a same-cycle wbValid (word dropped, overflow not set) and over a same-cycle rdEn (pop ignored, rdValid=0).
- Read: rdEn with count>0 gives rdData=mem[rdPtr] and rdValid=1 on the next cycle; rdPtr increments modulo DEPTH. Reads are legal in every state, including during capture.
- rdEn with count==0: no pointer change, rdValid=0, rdData holds its previous value.
- Simultaneous write and pop: both occur and count is unchanged. At count==DEPTH-1 in CAPTURE this does not enter DONE.
- Pointer wrap: both pointers wrap DEPTH-1 -> 0. FIFO order is preserved across wrap.
- Reset asserted mid-session: immediate return to the IDLE/reset values; captured data is lost.

Test Plan:
1. Reset, then arm with trigEn=0, then 3 valid words 0x11, 0x22, 0x33 -> count=3, state=CAPTURE. Three rdEn pulses -> rdData 0x11, 0x22, 0x33 each with a one-cycle rdValid; then empty=1.
2. arm with trigEn=1, trigValue=0xDEAD; feed 0x1, 0x2, 0xDEAD, 0x3 (all valid) -> state ARMED until 0xDEAD, then CAPTURE. count=2; reads return 0xDEAD, 0x3.
3. trigEn=0; 16 valid words 0..15 -> full=1, state=DONE. A 17th word 0x99 -> overflow=1 and count stays 16. arm -> overflow=0, count=0.
4. Wrap: fill 10, read 8, write 10 more (values 100..109) with no simultaneous pop. count goes 10 -> 2 -> 12; the 12 reads return words 8, 9, 100..109 in order.
5. At count=15 in CAPTURE, wbValid and rdEn in the same cycle -> count stays 15, state stays CAPTURE, rdValid=1.
6. rdEn on an empty buffer -> rdValid=0, rdData unchanged. Pull rst_n low mid-capture with count=5 -> asynchronously state=0, count=0, empty=1.
